relax_scheduler: RTL and testbench
==================================

Name: relax_scheduler

Overview:
- Frame-level sequencer for the rope-relaxation array, a chain of NUM_CORES cores with NODES_PER_CORE nodes each.
- On each frame request it snapshots the mouse position and drives a one-hot phase vector with 2*NODES_PER_CORE slots that all cores share.
- Runs ITERS relaxation sweeps. After each sweep it inserts a one-cycle boundary-exchange slot so cores can latch their neighbours' end nodes.
- Signals frame completion to the display/readout logic.

Parameters:
- NUM_CORES, 4, number of cores gated by core_en.
- NODES_PER_CORE, 5, nodes per core. The phase vector width is SLOTS = 2*NODES_PER_CORE.
- ITERS, 4, sweeps per frame; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- abort  in  1  cancels the frame in progress.
- hold  in  1  stalls the sweep (backpressure from readout).
- x_mouse_in  in  32  live mouse X.
- y_mouse_in  in  32  live mouse Y.
- x_mouse_out  out  32  frame-stable mouse X to all cores.
- y_mouse_out  out  32  frame-stable mouse Y to all cores.
- core_en  out  NUM_CORES  per-core step enable.
- phase  out  SLOTS  one-hot slot select to node control inputs.
- boundary_latch  out  1  boundary-exchange strobe.
- iter_count  out  8  completed sweeps in the current frame.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state IDLE;
  - phase, core_en, boundary_latch, iter_count, frame_done, busy all 0;
  - x/y_mouse_out 0.
- Reset dominates every other input, including mid-frame.
- States: IDLE, SWEEP, EXCHANGE, DONE. All outputs are registered (Moore).
- IDLE:
  - start=1 at an edge loads mouse_out <= mouse_in, phase <= 1 (bit 0), iter_count <= 0, then goes to SWEEP.
  - start=0 stays in IDLE.
  - mouse_out changes only on this accepting edge and holds until the next accepted start.
- SWEEP:
  - core_en = all ones and phase is one-hot.
  - Each edge with hold=0 rotates phase left by one.
  - The edge where phase[SLOTS-1]=1 and hold=0 goes to EXCHANGE with phase <= 0.
  - hold=1 freezes phase and gives core_en=0 in the following cycle. No slot is skipped or repeated.
- EXCHANGE (exactly 1 cycle, ignores hold):
  - boundary_latch=1, core_en=0, phase=0.
  - On exit iter_count increments.
  - If the new count equals ITERS, go to DONE; otherwise go to SWEEP with phase <= 1.
- DONE (1 cycle): frame_done=1, busy=1, then IDLE. start during DONE is ignored.
- start while busy: ignored, never queued.
- abort=1 in SWEEP or EXCHANGE: the next state is IDLE.
  - phase and core_en are cleared.
  - frame_done is not pulsed.
  - iter_count holds its last value.
  - mouse_out holds.
- abort in IDLE or DONE has no effect. If abort and hold are both high, abort wins.
- Latency with hold=0: frame_done is high in the cycle that begins ITERS*(SLOTS+1) edges after the accepting edge. Defaults: 4*11 = 44.
- iter_count never exceeds ITERS and never wraps.

Decomposition:
- Package relax_pkg:
  - state enum (IDLE, SWEEP, EXCHANGE, DONE);
  - ITER_W=8;
  - function slots(n) = 2*n;
  - localparam PHASE_RESET = 0.
- One sub-module, phase_ring: SLOTS-wide one-hot rotator with load-to-1, clear, and advance enable; it outputs last_slot. It replaces the per-core free-running circular shift so all cores stay in lockstep.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> all outputs 0, busy=0; after release, the first start is accepted.
- Nominal frame:
  - Stimulus: defaults; start pulse with x_mouse_in=0x00000064, y_mouse_in=0x000000C8.
  - Response: mouse_out latches those values.
  - phase sequence 1,2,4,...,0x200, then 0 with boundary_latch=1; this repeats 4 times.
  - iter_count steps 1..4; frame_done=1 exactly 44 cycles after the accepting edge; busy drops the cycle after.
- Hold: assert hold for 3 cycles while phase=0x010 -> phase stays 0x010, core_en=0 for those cycles; frame_done is delayed to cycle 47.
- Abort: abort at iter_count=2 during SWEEP -> next cycle IDLE, phase=0, no frame_done, iter_count=2; a new start restarts with iter_count=0.
- Ignored inputs: start pulses during SWEEP and DONE, and mouse_in changing mid-frame -> no restart, mouse_out unchanged, exactly one frame_done.
- Edge config: ITERS=1, NODES_PER_CORE=1 -> phase 1,2, then EXCHANGE, then DONE; frame_done at edge 3.

Source files
------------

// File: rtl/relax_pkg.sv
// relax_pkg: shared types and constants for the rope-relaxation frame sequencer.
//   state_e     - sequencer states (IDLE, SWEEP, EXCHANGE, DONE)
//   ITER_W      - width of the completed-sweep counter
//   PHASE_RESET - fill value of the phase vector when cleared or reset
//   slots(n)    - phase vector width for n nodes per core (two slots per node)
package relax_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWEEP    = 2'd1,
    EXCHANGE = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int   ITER_W      = 8;
  localparam logic PHASE_RESET = 1'b0;

  // Each node owns two control slots per sweep, so the ring is twice as wide as the node count.
  function automatic int slots(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/relax_scheduler_phase_ring.sv
// phase_ring: SLOTS-wide one-hot rotator shared by every core so that all
// cores step the same node slot in lockstep.
//   clk, reset  - clock, synchronous active-low reset (clears the ring)
//   load        - restart the ring at slot 0
//   clear       - empty the ring (no slot selected); wins over load/advance
//   advance     - rotate left by one slot
//   phase       - registered one-hot slot select
//   last_slot   - high while the final slot is selected
module phase_ring
  import relax_pkg::*;
#(
  parameter int SLOTS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             advance,
  output logic [SLOTS-1:0] phase,
  output logic             last_slot
);

  localparam logic [SLOTS-1:0] FIRST_SLOT = {{(SLOTS-1){1'b0}}, 1'b1};

  logic [SLOTS-1:0] phase_r;

  // Ring register: clear beats load beats advance; otherwise the selected slot holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_r <= {SLOTS{PHASE_RESET}};
    end else if (clear) begin
      phase_r <= {SLOTS{PHASE_RESET}};
    end else if (load) begin
      phase_r <= FIRST_SLOT;
    end else if (advance) begin
      phase_r <= {phase_r[SLOTS-2:0], phase_r[SLOTS-1]};
    end else begin
      phase_r <= phase_r;
    end
  end

  assign phase     = phase_r;
  assign last_slot = phase_r[SLOTS-1];

endmodule

// File: rtl/relax_scheduler.sv
// relax_scheduler: frame-level sequencer for the rope-relaxation core chain.
// On an accepted start it freezes the mouse position, runs ITERS sweeps of
// SLOTS one-hot phase slots, follows each sweep with a one-cycle boundary
// exchange slot, then pulses frame_done. All outputs are registered.
//   clk, reset           - clock, synchronous active-low reset
//   start                - frame request, honoured only in IDLE
//   abort                - cancel the frame (SWEEP/EXCHANGE only)
//   hold                 - stall the sweep for one cycle per asserted edge
//   x/y_mouse_in         - live mouse position
//   x/y_mouse_out        - mouse position captured at frame start
//   core_en              - per-core step enable
//   phase                - one-hot slot select shared by all cores
//   boundary_latch       - neighbour end-node exchange strobe
//   iter_count           - sweeps completed in the current frame
//   busy                 - frame in progress
//   frame_done           - one-cycle completion pulse
module relax_scheduler
  import relax_pkg::*;
#(
  parameter  int NUM_CORES      = 4,
  parameter  int NODES_PER_CORE = 5,
  parameter  int ITERS          = 4,
  localparam int SLOTS          = slots(NODES_PER_CORE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 hold,
  input  logic [31:0]          x_mouse_in,
  input  logic [31:0]          y_mouse_in,
  output logic [31:0]          x_mouse_out,
  output logic [31:0]          y_mouse_out,
  output logic [NUM_CORES-1:0] core_en,
  output logic [SLOTS-1:0]     phase,
  output logic                 boundary_latch,
  output logic [ITER_W-1:0]    iter_count,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [ITER_W-1:0] ITERS_C = ITER_W'(ITERS);

  state_e                 state_r, state_nxt_s;
  logic [NUM_CORES-1:0]   core_en_r, core_en_nxt_s;
  logic                   boundary_r, boundary_nxt_s;
  logic                   frame_done_r, frame_done_nxt_s;
  logic                   busy_r, busy_nxt_s;
  logic [ITER_W-1:0]      iter_r, iter_nxt_s, iter_inc_s;
  logic [31:0]            x_mouse_r, y_mouse_r;
  logic                   mouse_load_s;
  logic                   ring_load_s, ring_clear_s, ring_adv_s;
  logic                   last_slot_s;

  assign iter_inc_s = iter_r + {{(ITER_W-1){1'b0}}, 1'b1};

  phase_ring #(
    .SLOTS(SLOTS)
  ) u_phase_ring (
    .clk      (clk),
    .reset    (reset),
    .load     (ring_load_s),
    .clear    (ring_clear_s),
    .advance  (ring_adv_s),
    .phase    (phase),
    .last_slot(last_slot_s)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      core_en_r    <= {NUM_CORES{1'b0}};
      boundary_r   <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      iter_r       <= {ITER_W{1'b0}};
      x_mouse_r    <= 32'd0;
      y_mouse_r    <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      core_en_r    <= core_en_nxt_s;
      boundary_r   <= boundary_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      busy_r       <= busy_nxt_s;
      iter_r       <= iter_nxt_s;
      if (mouse_load_s) begin
        x_mouse_r <= x_mouse_in;
        y_mouse_r <= y_mouse_in;
      end else begin
        x_mouse_r <= x_mouse_r;
        y_mouse_r <= y_mouse_r;
      end
    end
  end

  // Next-state logic; abort outranks hold, EXCHANGE and DONE last exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = SWEEP;
        else       state_nxt_s = IDLE;
      end
      SWEEP: begin
        if (abort)                    state_nxt_s = IDLE;
        else if (!hold && last_slot_s) state_nxt_s = EXCHANGE;
        else                          state_nxt_s = SWEEP;
      end
      EXCHANGE: begin
        if (abort)                     state_nxt_s = IDLE;
        else if (iter_inc_s == ITERS_C) state_nxt_s = DONE;
        else                           state_nxt_s = SWEEP;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next output values and phase ring controls for the coming cycle.
  always_comb begin
    ring_load_s  = 1'b0;
    ring_clear_s = 1'b0;
    ring_adv_s   = 1'b0;
    mouse_load_s = 1'b0;
    iter_nxt_s   = iter_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          ring_load_s  = 1'b1;
          mouse_load_s = 1'b1;
          iter_nxt_s   = {ITER_W{1'b0}};
        end else begin
          ring_clear_s = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          ring_clear_s = 1'b1;
        end else if (hold) begin
          ring_adv_s = 1'b0;
        end else if (last_slot_s) begin
          ring_clear_s = 1'b1;
        end else begin
          ring_adv_s = 1'b1;
        end
      end
      EXCHANGE: begin
        // An aborted exchange does not count as a completed sweep.
        if (abort) begin
          ring_clear_s = 1'b1;
        end else begin
          iter_nxt_s = iter_inc_s;
          if (iter_inc_s == ITERS_C) ring_clear_s = 1'b1;
          else                       ring_load_s  = 1'b1;
        end
      end
      DONE:    ring_clear_s = 1'b1;
      default: ring_clear_s = 1'b1;
    endcase

    // A held sweep edge idles the cores for the following cycle.
    if (state_nxt_s == SWEEP && !(state_r == SWEEP && hold)) begin
      core_en_nxt_s = {NUM_CORES{1'b1}};
    end else begin
      core_en_nxt_s = {NUM_CORES{1'b0}};
    end
    boundary_nxt_s   = (state_nxt_s == EXCHANGE);
    frame_done_nxt_s = (state_nxt_s == DONE);
    busy_nxt_s       = (state_nxt_s != IDLE);
  end

  assign x_mouse_out    = x_mouse_r;
  assign y_mouse_out    = y_mouse_r;
  assign core_en        = core_en_r;
  assign boundary_latch = boundary_r;
  assign iter_count     = iter_r;
  assign busy           = busy_r;
  assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_relax_scheduler.sv
// Directed bench for relax_scheduler: default configuration plus a minimal
// ITERS=1 / NODES_PER_CORE=1 instance. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
module tb_relax_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        abort = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] x_in = 32'd0;
  logic [31:0] y_in = 32'd0;

  logic [31:0] x_out, y_out, x_out2, y_out2;
  logic [3:0]  core_en, core_en2;
  logic [9:0]  phase;
  logic [1:0]  phase2;
  logic        bl, bl2, busy, busy2, fd, fd2;
  logic [7:0]  iter, iter2;

  int checks = 0;
  int errors = 0;

  relax_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .x_mouse_in(x_in), .y_mouse_in(y_in), .x_mouse_out(x_out), .y_mouse_out(y_out),
    .core_en(core_en), .phase(phase), .boundary_latch(bl), .iter_count(iter),
    .busy(busy), .frame_done(fd)
  );

  relax_scheduler #(.NUM_CORES(4), .NODES_PER_CORE(1), .ITERS(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort), .hold(hold),
    .x_mouse_in(x_in), .y_mouse_in(y_in), .x_mouse_out(x_out2), .y_mouse_out(y_out2),
    .core_en(core_en2), .phase(phase2), .boundary_latch(bl2), .iter_count(iter2),
    .busy(busy2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; x_in = 32'h0000_1234; y_in = 32'h0000_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({phase, core_en, bl, iter, fd, busy, x_out, y_out} !== 90'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: phase=%h core_en=%h bl=%b iter=%0d fd=%b busy=%b x=%h y=%h expected all 0",
                 i, phase, core_en, bl, iter, fd, busy, x_out, y_out);
      end
    end
    reset = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, phase, core_en, iter, x_out, y_out} !== {1'b1, 10'h001, 4'hF, 8'd0, 32'h0000_1234, 32'h0000_5678}) begin
      errors++;
      $display("FAIL reset_first_start: busy=%b phase=%h core_en=%h iter=%0d x=%h y=%h expected 1 001 f 0 00001234 00005678",
               busy, phase, core_en, iter, x_out, y_out);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_cleanup: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_nominal();
    logic [9:0] e_phase;
    logic       e_bl, e_fd, e_busy;
    logic [3:0] e_ce;
    logic [7:0] e_it;
    x_in = 32'h0000_0064; y_in = 32'h0000_00C8; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (x_out !== 32'h0000_0064 || y_out !== 32'h0000_00C8) begin
      errors++;
      $display("FAIL nominal_mouse: x=%h y=%h expected 00000064 000000c8", x_out, y_out);
    end
    for (int k = 0; k <= 45; k++) begin
      if (k > 0) step();
      if (k < 44) begin
        e_busy = 1'b1; e_fd = 1'b0; e_it = 8'(k / 11);
        if ((k % 11) < 10) begin
          e_phase = 10'd1 << (k % 11); e_bl = 1'b0; e_ce = 4'hF;
        end else begin
          e_phase = 10'd0; e_bl = 1'b1; e_ce = 4'h0;
        end
      end else begin
        e_phase = 10'd0; e_bl = 1'b0; e_ce = 4'h0; e_it = 8'd4;
        e_fd = (k == 44); e_busy = (k == 44);
      end
      checks++;
      if ({phase, bl, core_en, iter, fd, busy} !== {e_phase, e_bl, e_ce, e_it, e_fd, e_busy}) begin
        errors++;
        $display("FAIL nominal_edge%0d: phase=%h bl=%b ce=%h iter=%0d fd=%b busy=%b expected phase=%h bl=%b ce=%h iter=%0d fd=%b busy=%b",
                 k, phase, bl, core_en, iter, fd, busy, e_phase, e_bl, e_ce, e_it, e_fd, e_busy);
      end
    end
  endtask

  task automatic test_hold();
    int k = 0;
    int done_at = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (k < 70 && done_at < 0) begin
      hold = (k >= 4 && k <= 6) || (k == 13);
      step();
      k++;
      if (k >= 5 && k <= 7) begin
        checks++;
        if (phase !== 10'h010 || core_en !== 4'h0) begin
          errors++;
          $display("FAIL hold_freeze_edge%0d: phase=%h ce=%h expected 010 0", k, phase, core_en);
        end
      end
      if (k == 8) begin
        checks++;
        if (phase !== 10'h020 || core_en !== 4'hF) begin
          errors++;
          $display("FAIL hold_resume: phase=%h ce=%h expected 020 f", phase, core_en);
        end
      end
      if (k == 14) begin
        checks++;
        if (phase !== 10'h001 || core_en !== 4'hF || iter !== 8'd1) begin
          errors++;
          $display("FAIL hold_in_exchange: phase=%h ce=%h iter=%0d expected 001 f 1", phase, core_en, iter);
        end
      end
      if (fd === 1'b1) done_at = k;
    end
    hold = 1'b0;
    checks++;
    if (done_at != 47) begin
      errors++;
      $display("FAIL hold_latency: frame_done at edge %0d expected 47", done_at);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_busy_drop: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    // Abort mid-sweep in the third sweep.
    x_in = 32'h0000_0001; y_in = 32'h0000_0002; start = 1'b1;
    step();
    start = 1'b0; x_in = 32'h0000_0099;
    for (int k = 1; k <= 25; k++) step();
    checks++;
    if (iter !== 8'd2 || phase !== 10'h008) begin
      errors++;
      $display("FAIL abort_setup: iter=%0d phase=%h expected 2 008", iter, phase);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, phase, core_en, iter, fd, x_out} !== {1'b0, 10'h000, 4'h0, 8'd2, 1'b0, 32'h0000_0001}) begin
      errors++;
      $display("FAIL abort_sweep: busy=%b phase=%h ce=%h iter=%0d fd=%b x=%h expected 0 000 0 2 0 00000001",
               busy, phase, core_en, iter, fd, x_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fd !== 1'b0 || busy !== 1'b0 || iter !== 8'd2) begin
        errors++;
        $display("FAIL abort_idle%0d: fd=%b busy=%b iter=%0d expected 0 0 2", i, fd, busy, iter);
      end
    end
    // Restart after abort.
    x_in = 32'h0000_0003; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({iter, phase, busy, x_out} !== {8'd0, 10'h001, 1'b1, 32'h0000_0003}) begin
      errors++;
      $display("FAIL abort_restart: iter=%0d phase=%h busy=%b x=%h expected 0 001 1 00000003", iter, phase, busy, x_out);
    end
    // Abort during the boundary exchange: the sweep is not counted.
    for (int k = 1; k <= 10; k++) step();
    checks++;
    if (bl !== 1'b1) begin
      errors++;
      $display("FAIL abort_exch_setup: bl=%b expected 1", bl);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, iter, bl, fd} !== {1'b0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_exchange: busy=%b iter=%0d bl=%b fd=%b expected 0 0 0 0", busy, iter, bl, fd);
    end
    // Abort and hold together: abort wins.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1; hold = 1'b1;
    step();
    abort = 1'b0; hold = 1'b0;
    checks++;
    if (busy !== 1'b0 || phase !== 10'h000) begin
      errors++;
      $display("FAIL abort_over_hold: busy=%b phase=%h expected 0 000", busy, phase);
    end
    // Reset mid-frame dominates.
    x_in = 32'h0000_0005; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({phase, core_en, bl, iter, fd, busy, x_out} !== 58'd0) begin
      errors++;
      $display("FAIL reset_midframe: phase=%h ce=%h bl=%b iter=%0d fd=%b busy=%b x=%h expected all 0",
               phase, core_en, bl, iter, fd, busy, x_out);
    end
  endtask

  task automatic test_ignored();
    int fd_count = 0;
    x_in = 32'hAAAA_0001; y_in = 32'h5555_0002; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      start = (k == 3) || (k == 44);
      abort = (k == 44);
      x_in  = (k == 3) ? 32'hDEAD_BEEF : 32'hAAAA_0001;
      y_in  = (k == 3) ? 32'h0BAD_F00D : 32'h5555_0002;
      step();
      start = 1'b0; abort = 1'b0;
      if (fd === 1'b1) fd_count++;
      if (k + 1 == 4) begin
        checks++;
        if (phase !== 10'h010 || x_out !== 32'hAAAA_0001 || y_out !== 32'h5555_0002) begin
          errors++;
          $display("FAIL ignored_start_sweep: phase=%h x=%h y=%h expected 010 aaaa0001 55550002", phase, x_out, y_out);
        end
      end
      if (k + 1 == 45) begin
        checks++;
        if (busy !== 1'b0 || iter !== 8'd4) begin
          errors++;
          $display("FAIL ignored_done_inputs: busy=%b iter=%0d expected 0 4", busy, iter);
        end
      end
      if (k + 1 == 46) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL ignored_no_queue: busy=%b expected 0", busy);
        end
      end
    end
    checks++;
    if (fd_count != 1 || x_out !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL ignored_single_done: frame_done count=%0d x=%h expected 1 aaaa0001", fd_count, x_out);
    end
  endtask

  task automatic test_edge_config();
    logic [1:0] e_phase [0:4];
    logic       e_bl    [0:4];
    logic       e_fd    [0:4];
    logic       e_busy  [0:4];
    logic [7:0] e_it    [0:4];
    e_phase = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    e_bl    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e_fd    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_it    = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      checks++;
      if ({phase2, bl2, fd2, busy2, iter2} !== {e_phase[k], e_bl[k], e_fd[k], e_busy[k], e_it[k]}) begin
        errors++;
        $display("FAIL edge_cfg_edge%0d: phase=%b bl=%b fd=%b busy=%b iter=%0d expected phase=%b bl=%b fd=%b busy=%b iter=%0d",
                 k, phase2, bl2, fd2, busy2, iter2, e_phase[k], e_bl[k], e_fd[k], e_busy[k], e_it[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_abort();
    test_ignored();
    test_edge_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
